// File: rtl/sub86_mem_pkg.sv
// Shared types and constants for the sub86 data-memory arbiter.
package sub86_mem_pkg;

    localparam int unsigned AW_DEF  = 17;
    localparam int unsigned SCW_DEF = 16;
    localparam int unsigned DW      = 32;

    // Size codes travel from requester to memory untouched.
    localparam logic [1:0] BEN_BYTE = 2'd0;
    localparam logic [1:0] BEN_HALF = 2'd1;
    localparam logic [1:0] BEN_WORD = 2'd2;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        CRD = 2'd1,
        HRD = 2'd2
    } state_t;

endpackage

// File: rtl/sub86_mem_arb.sv
// Shares one synchronous SRAM port between the sub86 data port and a host
// requester, and turns the SRAM read latency into core stalls via C_CE.
module sub86_mem_arb
    import sub86_mem_pkg::*;
#(
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned SCW = SCW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [31:0]       C_A,
    input  logic [31:0]       C_Q,
    input  logic [1:0]        C_BEN,
    output logic [31:0]       C_D,
    output logic              C_CE,
    input  logic              H_REQ,
    input  logic              H_WE,
    input  logic [31:0]       H_A,
    input  logic [31:0]       H_WDATA,
    input  logic [1:0]        H_BEN,
    output logic              H_GNT,
    output logic [31:0]       H_RDATA,
    output logic              H_RVALID,
    output logic              M_CS,
    output logic              M_WE,
    output logic [AW-1:0]     M_A,
    output logic [31:0]       M_WD,
    output logic [1:0]        M_BEN,
    input  logic [31:0]       M_RD,
    output logic [SCW-1:0]    STALLS
);

    state_t         state;
    state_t         state_nxt;
    logic           last_host;
    logic [31:0]    rd_hold;
    logic [SCW-1:0] stall_cnt;

    logic           host_pick;
    logic           grant_h;
    logic           grant_c;

    // Upper address bits are outside the memory and intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{C_A[31:AW], H_A[31:AW]};

    // Round-robin pick: host wins when alone or when the core had the last turn.
    assign host_pick = H_REQ & (~C_REQ | ~last_host);
    assign grant_h   = (state == RUN) & host_pick;
    assign grant_c   = (state == RUN) & ~host_pick & C_REQ;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a read grant opens a one-cycle data phase.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (grant_h) begin
                    state_nxt = H_WE ? RUN : HRD;
                end else if (grant_c) begin
                    state_nxt = C_WE ? RUN : CRD;
                end
            end
            CRD:     state_nxt = RUN;
            HRD:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs: memory mux, core enable, host handshake; all quiet during reset.
    always_comb begin
        C_CE     = 1'b1;
        C_D      = rd_hold;
        H_GNT    = 1'b0;
        H_RDATA  = '0;
        H_RVALID = 1'b0;
        M_CS     = 1'b0;
        M_WE     = 1'b0;
        M_A      = C_A[AW-1:0];
        M_WD     = C_Q;
        M_BEN    = C_BEN;
        case (state)
            RUN: begin
                if (grant_h) begin
                    H_GNT = 1'b1;
                    M_CS  = 1'b1;
                    M_WE  = H_WE;
                    M_A   = H_A[AW-1:0];
                    M_WD  = H_WDATA;
                    M_BEN = H_BEN;
                    C_CE  = ~C_REQ;
                end else if (grant_c) begin
                    M_CS  = 1'b1;
                    M_WE  = C_WE;
                    C_CE  = C_WE;
                end
            end
            CRD: begin
                C_D  = M_RD;
                C_CE = 1'b1;
            end
            HRD: begin
                H_RDATA  = M_RD;
                H_RVALID = 1'b1;
                C_CE     = ~C_REQ;
            end
            default: ;
        endcase
        if (RST) begin
            C_CE     = 1'b0;
            H_GNT    = 1'b0;
            H_RVALID = 1'b0;
            M_CS     = 1'b0;
            M_WE     = 1'b0;
        end
    end

    // Turn flag: remembers which side was granted most recently.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_host <= 1'b0;
        end else if (grant_h) begin
            last_host <= 1'b1;
        end else if (grant_c) begin
            last_host <= 1'b0;
        end
    end

    // Keep core read data stable after the cycle it was consumed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_hold <= '0;
        end else if (state == CRD) begin
            rd_hold <= M_RD;
        end
    end

    // Saturating count of cycles the core wanted to advance but could not.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (C_REQ && !C_CE && (stall_cnt != {SCW{1'b1}})) begin
            stall_cnt <= stall_cnt + SCW'(1);
        end
    end

    assign STALLS = stall_cnt;

endmodule

// File: tb/tb_sub86_mem_arb.sv
// Bench for sub86_mem_arb: transaction-level model plus directed scenarios.
module tb_sub86_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, h_req, h_we;
    logic [31:0] c_a, c_q, h_a, h_wdata;
    logic [1:0]  c_ben, h_ben;
    logic [31:0] c_d, h_rdata, m_wd, m_rd;
    logic        c_ce, h_gnt, h_rvalid, m_cs, m_we;
    logic [16:0] m_a;
    logic [1:0]  m_ben;
    logic [15:0] stalls;

    logic [31:0] c_d4, h_rdata4, m_wd4;
    logic        c_ce4, h_gnt4, h_rvalid4, m_cs4, m_we4;
    logic [16:0] m_a4;
    logic [1:0]  m_ben4;
    logic [3:0]  stalls4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sub86_mem_arb #(.AW(17), .SCW(16)) dut (
        .CLK(clk), .RST(rst),
        .C_REQ(c_req), .C_WE(c_we), .C_A(c_a), .C_Q(c_q), .C_BEN(c_ben),
        .C_D(c_d), .C_CE(c_ce),
        .H_REQ(h_req), .H_WE(h_we), .H_A(h_a), .H_WDATA(h_wdata), .H_BEN(h_ben),
        .H_GNT(h_gnt), .H_RDATA(h_rdata), .H_RVALID(h_rvalid),
        .M_CS(m_cs), .M_WE(m_we), .M_A(m_a), .M_WD(m_wd), .M_BEN(m_ben),
        .M_RD(m_rd), .STALLS(stalls)
    );

    sub86_mem_arb #(.AW(17), .SCW(4)) dut4 (
        .CLK(clk), .RST(rst),
        .C_REQ(c_req), .C_WE(c_we), .C_A(c_a), .C_Q(c_q), .C_BEN(c_ben),
        .C_D(c_d4), .C_CE(c_ce4),
        .H_REQ(h_req), .H_WE(h_we), .H_A(h_a), .H_WDATA(h_wdata), .H_BEN(h_ben),
        .H_GNT(h_gnt4), .H_RDATA(h_rdata4), .H_RVALID(h_rvalid4),
        .M_CS(m_cs4), .M_WE(m_we4), .M_A(m_a4), .M_WD(m_wd4), .M_BEN(m_ben4),
        .M_RD(m_rd), .STALLS(stalls4)
    );

    logic unused_dut4;
    assign unused_dut4 = ^{c_d4, h_rdata4, m_wd4, m_we4, m_a4, m_ben4};

    // Synchronous SRAM driven by the main instance.
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (m_cs) begin
            if (m_we) sram[m_a[9:0]] <= m_wd;
            else      m_rd <= sram[m_a[9:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pending read data phases, turn flag, memory image, stall counts.
    logic        core_due, host_due, last_h;
    logic [31:0] core_val, host_val, hold;
    logic [31:0] mmem [0:1023];
    int          st16, st4;
    bit          chk_on = 1'b0;

    always @(negedge clk) begin
        logic        ecce, egnt, erv, ecs, ewe;
        logic [31:0] ehrd, ecd, ea, ewd;
        logic [1:0]  eben;
        if (chk_on) begin
            ecce = 1'b1; egnt = 1'b0; erv = 1'b0; ecs = 1'b0; ewe = 1'b0;
            ehrd = 32'h0; ecd = hold; ea = {15'h0, c_a[16:0]}; ewd = c_q; eben = c_ben;
            if (rst) begin
                core_due = 1'b0; host_due = 1'b0; last_h = 1'b0; hold = 32'h0;
                st16 = 0; st4 = 0;
                ecce = 1'b0; ecd = 32'h0;
            end else if (core_due) begin
                ecd = core_val;
                hold = core_val;
                core_due = 1'b0;
            end else if (host_due) begin
                erv = 1'b1; ehrd = host_val; ecce = !c_req;
                host_due = 1'b0;
            end else if (h_req && (!c_req || !last_h)) begin
                egnt = 1'b1; ecs = 1'b1; ewe = h_we; ecce = !c_req;
                ea = {15'h0, h_a[16:0]}; ewd = h_wdata; eben = h_ben;
                if (h_we) mmem[h_a[9:0]] = h_wdata;
                else begin host_due = 1'b1; host_val = mmem[h_a[9:0]]; end
                last_h = 1'b1;
            end else if (c_req) begin
                ecs = 1'b1; ewe = c_we; ecce = c_we;
                if (c_we) mmem[c_a[9:0]] = c_q;
                else begin core_due = 1'b1; core_val = mmem[c_a[9:0]]; end
                last_h = 1'b0;
            end
            chk("c_ce", c_ce, ecce);
            chk("c_ce4", c_ce4, ecce);
            chk("h_gnt", h_gnt, egnt);
            chk("h_gnt4", h_gnt4, egnt);
            chk("h_rvalid", h_rvalid, erv);
            chk("h_rvalid4", h_rvalid4, erv);
            chk("m_cs", m_cs, ecs);
            chk("m_cs4", m_cs4, ecs);
            chk("h_rdata", h_rdata, ehrd);
            chk("c_d", c_d, ecd);
            chk("stalls", 32'(stalls), 32'(st16));
            chk("stalls4", 32'(stalls4), 32'(st4));
            if (ecs || rst) chk("m_we", m_we, ewe);
            if (!rst) begin
                chk("m_a", 32'(m_a), ea);
                chk("m_wd", m_wd, ewd);
                chk("m_ben", 32'(m_ben), 32'(eben));
            end
            if (!rst && c_req && !ecce) begin
                if (st16 < 65535) st16++;
                if (st4 < 15) st4++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core holds its request until it observes C_CE=1.
    task automatic core_op(input logic we, input logic [31:0] a, input logic [31:0] q);
        bit done = 1'b0;
        int n = 0;
        c_req = 1'b1; c_we = we; c_a = a; c_q = q; c_ben = 2'd2;
        while (!done && n < 12) begin
            @(negedge clk);
            done = c_ce;
            n++;
        end
        chk("core_done", 32'(done), 32'd1);
        tick();
        c_req = 1'b0;
    endtask

    // Host holds H_REQ until granted; loads check the returned word.
    task automatic host_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp);
        bit got = 1'b0;
        int n = 0;
        h_req = 1'b1; h_we = we; h_a = a; h_wdata = d; h_ben = 2'd2;
        while (!got && n < 12) begin
            @(negedge clk);
            got = h_gnt;
            n++;
        end
        chk("host_granted", 32'(got), 32'd1);
        tick();
        h_req = 1'b0;
        if (!we) begin
            @(negedge clk);
            chk("host_rvalid_lit", 32'(h_rvalid), 32'd1);
            chk("host_rdata_lit", h_rdata, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] gnt_pat, ce_pat;
        for (int i = 0; i < 1024; i++) begin
            sram[i] = 32'h0;
            mmem[i] = 32'h0;
        end
        m_rd = 32'h0;
        rst = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_a = 32'h0; c_q = 32'h0; c_ben = 2'd0;
        h_req = 1'b0; h_we = 1'b0; h_a = 32'h0; h_wdata = 32'h0; h_ben = 2'd0;
        core_due = 1'b0; host_due = 1'b0; last_h = 1'b0; hold = 32'h0;
        core_val = 32'h0; host_val = 32'h0; st16 = 0; st4 = 0;
        chk_on = 1'b1;

        // Reset values.
        tick();
        @(negedge clk);
        chk("rst_c_ce", 32'(c_ce), 32'd0);
        chk("rst_m_cs", 32'(m_cs), 32'd0);
        chk("rst_stalls", 32'(stalls), 32'd0);
        tick();
        rst = 1'b0;

        // Preload host word at 0x200 (leaves host as last winner).
        host_op(1'b1, 32'h200, 32'h12345678, 32'h0);

        // Core store, host idle: zero-stall single cycle.
        c_req = 1'b1; c_we = 1'b1; c_a = 32'h100; c_q = 32'hDEADBEEF; c_ben = 2'd2;
        @(negedge clk);
        chk("st_m_cs", 32'(m_cs), 32'd1);
        chk("st_m_we", 32'(m_we), 32'd1);
        chk("st_m_a", 32'(m_a), 32'h100);
        chk("st_c_ce", 32'(c_ce), 32'd1);
        tick();
        c_req = 1'b0;
        @(negedge clk);
        chk("st_stalls", 32'(stalls), 32'd0);

        // Core load: one stall, data held afterwards.
        tick();
        core_op(1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("ld_c_d_hold", c_d, 32'hDEADBEEF);
        chk("ld_stalls", 32'(stalls), 32'd1);

        // Simultaneous host and core loads: host first, core waits three cycles.
        tick();
        fork
            host_op(1'b0, 32'h200, 32'h0, 32'h12345678);
            core_op(1'b0, 32'h100, 32'h0);
        join
        @(negedge clk);
        chk("both_stalls", 32'(stalls), 32'd4);
        chk("both_c_d", c_d, 32'hDEADBEEF);

        // Continuous host and core stores alternate, host first.
        tick();
        gnt_pat = 8'h0; ce_pat = 8'h0;
        h_req = 1'b1; h_we = 1'b1; h_a = 32'h300; h_ben = 2'd1;
        c_req = 1'b1; c_we = 1'b1; c_a = 32'h304; c_ben = 2'd0;
        for (int i = 0; i < 8; i++) begin
            h_wdata = 32'hA000_0000 + 32'(i);
            c_q     = 32'hB000_0000 + 32'(i);
            @(negedge clk);
            gnt_pat[i] = h_gnt;
            ce_pat[i]  = c_ce;
            tick();
        end
        h_req = 1'b0; c_req = 1'b0;
        @(negedge clk);
        chk("alt_gnt_pattern", 32'(gnt_pat), 32'h55);
        chk("alt_ce_pattern", 32'(ce_pat), 32'hAA);
        chk("alt_stalls", 32'(stalls), 32'd8);

        // Reset during the core read data phase; the load is reissued.
        tick();
        c_req = 1'b1; c_we = 1'b0; c_a = 32'h100;
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rcrd_c_ce", 32'(c_ce), 32'd0);
        chk("rcrd_m_cs", 32'(m_cs), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rcrd_stalls", 32'(stalls), 32'd0);
        chk("rcrd_reissue_cs", 32'(m_cs), 32'd1);
        chk("rcrd_reissue_ce", 32'(c_ce), 32'd0);
        tick();
        @(negedge clk);
        chk("rcrd_data_ce", 32'(c_ce), 32'd1);
        chk("rcrd_data", c_d, 32'hDEADBEEF);
        tick();
        c_req = 1'b0;

        // Reset during the host read data phase: no read-valid emerges.
        h_req = 1'b1; h_we = 1'b0; h_a = 32'h200;
        @(negedge clk);
        tick();
        h_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rhrd_rvalid", 32'(h_rvalid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rhrd_rvalid_after", 32'(h_rvalid), 32'd0);

        // Sustained contention: 3 stalls every 4 cycles, 28 cycles.
        tick();
        c_req = 1'b1; c_we = 1'b0; c_a = 32'h100;
        h_req = 1'b1; h_we = 1'b0; h_a = 32'h200;
        repeat (28) tick();
        c_req = 1'b0; h_req = 1'b0;
        @(negedge clk);
        chk("sat_stalls16", 32'(stalls), 32'd21);
        chk("sat_stalls4", 32'(stalls4), 32'd15);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
